// File: rtl/uart_pkg.sv
// Shared UART definitions: default line parameters, receiver state encoding and
// baud-timing helpers. Used by uart_rx and uart_tx.
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;
   localparam int UART_BAUD_RATE  = 115200;
   localparam int UART_CLK_FREQ   = 100_000_000;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   function automatic int pulse_width(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic int half_pulse_width(input int pw);
      return pw / 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line conditioning for uart_rx: 2-FF synchroniser, previous-sample register and
// falling-edge detector; every line stage resets to the idle (high) level.
module uart_rx_sync (
   input  logic clk,
   input  logic rstn,
   input  logic rx_sig,
   output logic sync_out,
   output logic fall_edge
);

   logic       meta_q;
   logic       sync_q;
   logic       prev_q;
   logic [1:0] fill_q;
   logic       armed_q;

   // Edges count only after a genuine high has crossed the synchroniser, so a line
   // already low when reset releases cannot masquerade as a start bit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         prev_q  <= 1'b1;
         fill_q  <= 2'b00;
         armed_q <= 1'b0;
      end else begin
         meta_q  <= rx_sig;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         fill_q  <= {fill_q[0], 1'b1};
         armed_q <= armed_q | (fill_q[1] & sync_q);
      end
   end

   assign sync_out  = sync_q;
   assign fall_edge = armed_q & prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: serial receiver with bit-centre sampling and a one-word valid/ready
// holding register. Define UART_RX_PARITY_EN for 8E1 frames and the parity_err port.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int BAUD_RATE  = UART_BAUD_RATE,
   parameter int CLK_FREQ   = UART_CLK_FREQ
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  rx_sig,
   output logic [DATA_WIDTH-1:0] data_to_sink,
   output logic                  valid_to_sink,
   input  logic                  ready_from_sink,
   output logic                  frame_err,
   output logic                  overrun_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic                  parity_err
`endif
);

   localparam int PULSE_WIDTH      = pulse_width(CLK_FREQ, BAUD_RATE);
   localparam int HALF_PULSE_WIDTH = half_pulse_width(PULSE_WIDTH);
   localparam int LB_DATA_WIDTH    = $clog2(DATA_WIDTH);
   localparam int LB_PULSE_WIDTH   = $clog2(PULSE_WIDTH);
   localparam int CNT_W            = LB_PULSE_WIDTH + 1;

   localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(PULSE_WIDTH - 1);
   localparam logic [CNT_W-1:0]         CNT_HALF = CNT_W'(HALF_PULSE_WIDTH - 1);
   localparam logic [LB_DATA_WIDTH-1:0] LAST_BIT = LB_DATA_WIDTH'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
   localparam rx_state_t AFTER_DATA = PARITY;
`else
   localparam rx_state_t AFTER_DATA = STOP;
`endif

   logic rx_s;
   logic fall_edge;

   rx_state_t               state_q, state_d;
   logic [CNT_W-1:0]        clk_cnt_q, clk_cnt_d;
   logic [LB_DATA_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    frame_err_q, frame_err_d;
   logic                    overrun_err_q, overrun_err_d;
   logic                    handshake;
   logic                    cnt_zero;
   logic                    word_ok;
`ifdef UART_RX_PARITY_EN
   logic                    par_bad_q, par_bad_d;
   logic                    parity_err_q, parity_err_d;
`endif

   uart_rx_sync u_sync (
      .clk       (clk),
      .rstn      (rstn),
      .rx_sig    (rx_sig),
      .sync_out  (rx_s),
      .fall_edge (fall_edge)
   );

   assign handshake = valid_q & ready_from_sink;
   assign cnt_zero  = (clk_cnt_q == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         clk_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         data_q        <= '0;
         valid_q       <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q     <= 1'b0;
         parity_err_q  <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         clk_cnt_q     <= clk_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         data_q        <= data_d;
         valid_q       <= valid_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q     <= par_bad_d;
         parity_err_q  <= parity_err_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      clk_cnt_d     = clk_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      data_d        = data_q;
      valid_d       = valid_q & ~handshake;
      frame_err_d   = 1'b0;
      overrun_err_d = 1'b0;
      word_ok       = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d     = par_bad_q;
      parity_err_d  = 1'b0;
`endif

      // Every state but IDLE times a bit; the case below only acts on expiry.
      if (state_q != IDLE && !cnt_zero)
         clk_cnt_d = clk_cnt_q - 1'b1;

      case (state_q)
         IDLE: begin
            if (fall_edge) begin
               clk_cnt_d = CNT_HALF;
               state_d   = START;
            end
         end
         START: begin
            if (cnt_zero) begin
               if (!rx_s) begin
                  clk_cnt_d = CNT_FULL;
                  bit_cnt_d = '0;
                  state_d   = DATA;
               end else begin
                  state_d   = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt_zero) begin
               shift_d[bit_cnt_q] = rx_s;
               clk_cnt_d          = CNT_FULL;
               if (bit_cnt_q == LAST_BIT)
                  state_d = AFTER_DATA;
               else
                  bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_zero) begin
               par_bad_d = rx_s ^ (^shift_q);
               clk_cnt_d = CNT_FULL;
               state_d   = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt_zero) begin
               state_d     = IDLE;
               frame_err_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
               parity_err_d = par_bad_q;
               word_ok      = rx_s & ~par_bad_q;
`else
               word_ok      = rx_s;
`endif
               // A handshake this cycle frees the holding register for the new word.
               if (word_ok) begin
                  if (!valid_q || handshake) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     overrun_err_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign data_to_sink  = data_q;
   assign valid_to_sink = valid_q;
   assign frame_err     = frame_err_q;
   assign overrun_err   = overrun_err_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err    = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level line model, scheduled-outcome
// reference of the holding register, plus a default-parameter latency check.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int DW   = 8;
   localparam int BAUD = 115200;
   localparam int CF   = 3_686_400;   // 32 clocks per bit keeps frames short
   localparam int P    = 32;
   localparam int H    = 16;
   localparam int PD   = 868;
`ifdef UART_RX_PARITY_EN
   localparam int PB     = 1;
   localparam int LIT_S  = 339;       // 3 + 16 + 10*32
   localparam int LIT_D  = 9117;      // 3 + 434 + 10*868
`else
   localparam int PB     = 0;
   localparam int LIT_S  = 307;       // 3 + 16 + 9*32
   localparam int LIT_D  = 8249;      // 3 + 434 + 9*868
`endif
   localparam int NSEG = DW + 2 + PB;
   localparam int LAT  = 3;           // line change to detect edge: two sync flops + edge register

   typedef struct {
      int            due;
      logic [DW-1:0] data;
      int            kind;   // 0 good word, 1 bad stop, 2 bad parity
   } ev_t;

   logic          clk = 1'b0;
   logic          rstn, rx, rdy;
   logic [DW-1:0] data;
   logic          valid, ferr, oerr;
   logic          rstn_d, rx_d;
   logic [DW-1:0] data_d;
   logic          valid_d, ferr_d, oerr_d;
`ifdef UART_RX_PARITY_EN
   logic          perr, perr_d;
   int            perr_cnt = 0;
`endif

   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   int  ready_mode = 1;
   ev_t evq[$];
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_data = '0;
   logic          hs_prev = 1'b0;
   int            ferr_cnt = 0, oerr_cnt = 0, dferr_cnt = 0;
   int            rise_cyc = -1;
   logic [DW-1:0] rise_data = '0;
   logic          v_last = 1'b0;
   logic          done_d = 1'b0;

   uart_rx #(.DATA_WIDTH(DW), .BAUD_RATE(BAUD), .CLK_FREQ(CF)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .rx_sig          (rx),
      .data_to_sink    (data),
      .valid_to_sink   (valid),
      .ready_from_sink (rdy),
      .frame_err       (ferr),
      .overrun_err     (oerr)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err      (perr)
`endif
   );

   uart_rx u_dflt (
      .clk             (clk),
      .rstn            (rstn_d),
      .rx_sig          (rx_d),
      .data_to_sink    (data_d),
      .valid_to_sink   (valid_d),
      .ready_from_sink (1'b1),
      .frame_err       (ferr_d),
      .overrun_err     (oerr_d)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err      (perr_d)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   function automatic logic [NSEG-1:0] build_segs(input logic [DW-1:0] d, input bit bad_stop,
                                                 input bit bad_par);
      logic [NSEG-1:0] s;
      s        = '0;
      s[DW:1]  = d;
      if (PB == 1) s[DW+1] = (^d) ^ bad_par;
      s[NSEG-1] = ~bad_stop;
      return s;
   endfunction

   // Drives one frame from just after a rising edge; schedules its outcome at the
   // receiver's stop-sample time, which depends only on the start edge.
   task automatic send_frame(input logic [DW-1:0] d, input int bitlen, input bit bad_stop,
                             input bit bad_par);
      logic [NSEG-1:0] segs;
      ev_t ev;
      segs    = build_segs(d, bad_stop, bad_par);
      ev.due  = cyc + LAT + H + (DW + 1 + PB) * P;
      ev.data = d;
      ev.kind = bad_stop ? 1 : (bad_par ? 2 : 0);
      evq.push_back(ev);
      for (int j = 0; j < NSEG; j++) begin
         rx = segs[j];
         repeat (bitlen) @(posedge clk);
         #1;
      end
      rx = 1'b1;
   endtask

   initial begin
      forever begin
         tick();
         case (ready_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Reference holding register, compared against the DUT every cycle.
   always @(negedge clk) begin
      logic e_f, e_o, nv;
      ev_t  ev;
`ifdef UART_RX_PARITY_EN
      logic e_p;
      e_p = 1'b0;
`endif
      e_f = 1'b0;
      e_o = 1'b0;
      if (!rstn) begin
         evq.delete();
         m_valid = 1'b0;
         hs_prev = 1'b0;
         chk("rst_valid", 32'(valid), 0);
         chk("rst_data", 32'(data), 0);
         chk("rst_frame_err", 32'(ferr), 0);
         chk("rst_overrun_err", 32'(oerr), 0);
      end else begin
         nv = hs_prev ? 1'b0 : m_valid;
         if (evq.size() > 0 && evq[0].due == cyc) begin
            ev = evq.pop_front();
            case (ev.kind)
               1: e_f = 1'b1;
`ifdef UART_RX_PARITY_EN
               2: e_p = 1'b1;
`endif
               default: begin
                  if (!m_valid || hs_prev) begin
                     nv     = 1'b1;
                     m_data = ev.data;
                  end else begin
                     e_o = 1'b1;
                  end
               end
            endcase
         end
         m_valid = nv;
         chk("valid", 32'(valid), 32'(m_valid));
         if (m_valid) chk("data", 32'(data), 32'(m_data));
         chk("frame_err", 32'(ferr), 32'(e_f));
         chk("overrun_err", 32'(oerr), 32'(e_o));
`ifdef UART_RX_PARITY_EN
         chk("parity_err", 32'(perr), 32'(e_p));
`endif
         hs_prev = m_valid & rdy;
      end
   end

   always @(negedge clk) begin
      if (valid && !v_last) begin
         rise_cyc  = cyc;
         rise_data = data;
      end
      v_last = valid;
      if (ferr) ferr_cnt++;
      if (oerr) oerr_cnt++;
      if (ferr_d) dferr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (perr) perr_cnt++;
`endif
   end

   // Default-parameter instance: one 0xA5 frame at the real 868-clock bit time.
   initial begin
      logic [NSEG-1:0] segs;
      logic [DW-1:0]   dd;
      int              s, rc;
      bit              seen;
      logic            v2;
      rstn_d = 1'b0;
      rx_d   = 1'b1;
      rc     = -1;
      dd     = '0;
      v2     = 1'b1;
      seen   = 1'b0;
      repeat (4) tick();
      rstn_d = 1'b1;
      repeat (10) tick();
      segs = build_segs(8'hA5, 1'b0, 1'b0);
      s    = cyc;
      fork
         begin
            for (int j = 0; j < NSEG; j++) begin
               rx_d = segs[j];
               repeat (PD) @(posedge clk);
               #1;
            end
            rx_d = 1'b1;
         end
         begin
            for (int i = 0; i < 12000 && !seen; i++) begin
               @(negedge clk);
               if (valid_d) begin
                  seen = 1'b1;
                  rc   = cyc;
                  dd   = data_d;
               end
            end
            @(negedge clk);
            v2 = valid_d;
         end
      join
      chk("dflt_seen", 32'(seen), 1);
      chk("dflt_latency", 32'(rc - s), LIT_D);
      chk("dflt_data", 32'(dd), 32'hA5);
      chk("dflt_valid_one_cycle", 32'(v2), 0);
      chk("dflt_no_frame_err", 32'(dferr_cnt), 0);
      done_d = 1'b1;
   end

   initial begin
      int            s, r0, f0;
      rstn = 1'b0;
      rx   = 1'b1;
      rdy  = 1'b1;
      repeat (4) tick();
      rstn = 1'b1;
      repeat (10) tick();

      // first frame: latency and data pinned by hand
      s = cyc;
      send_frame(8'hA5, P, 1'b0, 1'b0);
      idle(40);
      chk("a5_latency", 32'(rise_cyc - s), LIT_S);
      chk("a5_data", 32'(rise_data), 32'hA5);
      chk("a5_valid_cleared", 32'(valid), 0);

      // short low glitch, then a real frame
      r0 = rise_cyc;
      rx = 1'b0;
      repeat (10) tick();
      idle(60);
      chk("glitch_no_valid", 32'(rise_cyc), 32'(r0));
      chk("glitch_no_frame_err", 32'(ferr_cnt), 0);
      send_frame(8'h3C, P, 1'b0, 1'b0);
      idle(40);
      chk("3c_data", 32'(rise_data), 32'h3C);

      // bad stop bit, then a good repeat
      r0 = rise_cyc;
      send_frame(8'h55, P, 1'b1, 1'b0);
      idle(20);
      chk("bad_stop_frame_err", 32'(ferr_cnt), 1);
      chk("bad_stop_no_valid", 32'(rise_cyc), 32'(r0));
      s = cyc;
      send_frame(8'h55, P, 1'b0, 1'b0);
      idle(40);
      chk("55_latency", 32'(rise_cyc - s), LIT_S);
      chk("55_data", 32'(rise_data), 32'h55);

      // overrun with the sink stalled
      ready_mode = 0;
      idle(2);
      send_frame(8'h11, P, 1'b0, 1'b0);
      send_frame(8'h22, P, 1'b0, 1'b0);
      idle(40);
      chk("overrun_count", 32'(oerr_cnt), 1);
      chk("overrun_held_data", 32'(data), 32'h11);
      chk("overrun_held_valid", 32'(valid), 1);
      ready_mode = 1;
      idle(4);
      chk("overrun_drained", 32'(valid), 0);

`ifdef UART_RX_PARITY_EN
      r0 = rise_cyc;
      send_frame(8'h81, P, 1'b0, 1'b1);
      idle(20);
      chk("parity_err_count", 32'(perr_cnt), 1);
      chk("parity_word_dropped", 32'(rise_cyc), 32'(r0));
`endif

      // randomized words, slight baud skew, random sink stalls
      ready_mode = 2;
      for (int i = 0; i < 40; i++) begin
         logic [DW-1:0] d;
         int            bl, gap;
         bit            bs, bp;
         d   = DW'($urandom);
         bl  = P - 1 + $urandom_range(0, 2);
         bs  = ($urandom_range(0, 9) == 0);
         bp  = (PB == 1) && !bs && ($urandom_range(0, 7) == 0);
         gap = $urandom_range(0, 20) + (bs ? 5 : 0);
         send_frame(d, bl, bs, bp);
         idle(gap);
      end
      ready_mode = 1;
      idle(20);

      // reset during data bit 4, released with the line low
      rx = 1'b0;
      repeat (P) tick();
      for (int b = 0; b < 4; b++) begin
         rx = (b % 2 == 1);
         repeat (P) tick();
      end
      rx = 1'b1;
      repeat (P / 2) tick();
      rstn = 1'b0;
      rx   = 1'b0;
      repeat (3) tick();
      chk("midreset_valid", 32'(valid), 0);
      chk("midreset_data", 32'(data), 0);
      rstn = 1'b1;
      r0 = rise_cyc;
      f0 = ferr_cnt;
      repeat (100) tick();
      idle(40);
      chk("post_reset_no_valid", 32'(rise_cyc), 32'(r0));
      chk("post_reset_no_frame_err", 32'(ferr_cnt), 32'(f0));
      s = cyc;
      send_frame(8'hF0, P, 1'b0, 1'b0);
      idle(40);
      chk("f0_latency", 32'(rise_cyc - s), LIT_S);
      chk("f0_data", 32'(rise_data), 32'hF0);

      idle(30);
      chk("events_drained", 32'(evq.size()), 0);
      for (int i = 0; i < 20000 && !done_d; i++) tick();
      chk("dflt_done", 32'(done_d), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
